// File: rtl/input_vc_arbiter.sv
// Per-input-port VC scheduler: selects an input VC, requests its output, holds the grant until last beat.
// INPUT_ARB_STRICT_PRIO_EN: strict priority between classes with per-class round-robin; otherwise one round-robin over all VCs.

module input_vc_arbiter_rr_pick #(
   parameter int W  = 3,
   parameter int IW = 2
) (
   input  logic [W-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);
   logic [2*W-1:0] dbl;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;

   // rotate so that bit 0 is the pointer position, then find the first set bit
   assign dbl = {req, req} >> ptr;
   assign any = |req;

   always_comb begin
      off = '0;
      for (int k = W-1; k >= 0; k--)
         if (dbl[k]) off = IW'(k);
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IW+1)'(W)) sum = sum - (IW+1)'(W);
      idx = sum[IW-1:0];
   end
endmodule

module input_vc_arbiter #(
   parameter int vc_num     = 3,
   parameter int prio_num   = 2,
   parameter int output_num = 8,
   parameter int logVcPrio  = $clog2(prio_num*vc_num),
   parameter int logOutput  = $clog2(output_num)
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [prio_num*vc_num-1:0]              has_packet,
   input  logic [prio_num*vc_num-1:0][logOutput-1:0] dest_i,
   input  logic [prio_num*vc_num-1:0][logVcPrio-1:0] output_vc_i,
   input  logic                                    cts,
   input  logic                                    last,
   output logic                                    o_req,
   output logic [logOutput-1:0]                    o_dest,
   output logic [logVcPrio-1:0]                    o_output_vc,
   output logic [logVcPrio-1:0]                    selected_vc,
   output logic [prio_num*vc_num-1:0]              o_grant,
   output logic                                    o_busy
);
   localparam int N = prio_num*vc_num;

   typedef enum logic [1:0] {IDLE, REQ, GRANTED} state_t;

   state_t               state, state_n;
   logic                 load, rr_adv;
   logic [logVcPrio-1:0] pick_vc;

`ifdef INPUT_ARB_STRICT_PRIO_EN
   localparam int logPrio = (prio_num > 1) ? $clog2(prio_num) : 1;

   logic [prio_num-1:0]                cls_any;
   logic [prio_num-1:0][logVcPrio-1:0] cls_idx, rr, rr_loc;
   logic [logPrio-1:0]                 pick_cls, sel_cls;
   logic [logVcPrio-1:0]               sel_base;

   for (genvar c = 0; c < prio_num; c++) begin : g_cls
      assign rr_loc[c] = rr[c] - logVcPrio'(c*vc_num);
      input_vc_arbiter_rr_pick #(.W(vc_num), .IW(logVcPrio)) u_pick (
         .req (has_packet[c*vc_num +: vc_num]),
         .ptr (rr_loc[c]),
         .any (cls_any[c]),
         .idx (cls_idx[c])
      );
   end

   // ascending scan: the highest non-empty class overrides the lower ones
   always_comb begin
      pick_vc  = '0;
      pick_cls = '0;
      for (int c = 0; c < prio_num; c++)
         if (cls_any[c]) begin
            pick_vc  = logVcPrio'(c*vc_num) + cls_idx[c];
            pick_cls = logPrio'(c);
         end
   end

   assign sel_base = logVcPrio'(int'(sel_cls)*vc_num);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < prio_num; c++) rr[c] <= logVcPrio'(c*vc_num);
         sel_cls <= '0;
      end else begin
         if (load) sel_cls <= pick_cls;
         if (rr_adv)
            rr[sel_cls] <= (selected_vc == sel_base + logVcPrio'(vc_num-1)) ?
                           sel_base : selected_vc + logVcPrio'(1);
      end
   end
`else
   logic [logVcPrio-1:0] rr;
   logic                 pick_any;

   input_vc_arbiter_rr_pick #(.W(N), .IW(logVcPrio)) u_pick (
      .req (has_packet),
      .ptr (rr),
      .any (pick_any),
      .idx (pick_vc)
   );

   always_ff @(posedge clk) begin
      if (reset)
         rr <= '0;
      else if (rr_adv)
         rr <= (selected_vc == logVcPrio'(N-1)) ? '0 : selected_vc + logVcPrio'(1);
   end
`endif

   always_comb begin
      state_n = state;
      load    = 1'b0;
      rr_adv  = 1'b0;
      case (state)
         IDLE:
            if (|has_packet) begin
               state_n = REQ;
               load    = 1'b1;
            end
         REQ:
            // cts wins over a simultaneous withdrawal
            if (cts)                           state_n = GRANTED;
            else if (!has_packet[selected_vc]) state_n = IDLE;
         GRANTED:
            if (last) begin
               state_n = IDLE;
               rr_adv  = 1'b1;
            end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         selected_vc <= '0;
         o_dest      <= '0;
         o_output_vc <= '0;
      end else begin
         state <= state_n;
         if (load) begin
            selected_vc <= pick_vc;
            o_dest      <= dest_i[pick_vc];
            o_output_vc <= output_vc_i[pick_vc];
         end
      end
   end

   assign o_req  = (state == REQ);
   assign o_busy = (state != IDLE);

   always_comb begin
      o_grant = '0;
      if (state == GRANTED) o_grant[selected_vc] = 1'b1;
   end
endmodule

// File: tb/tb_input_vc_arbiter.sv
// Randomized + directed bench for input_vc_arbiter against a behavioural scheduler model.
module tb_input_vc_arbiter;
   localparam int VC = 3, PRIO = 2, N = 6, LV = 3, LO = 3;

   logic                   clk = 0, reset = 1;
   logic [N-1:0]           has_packet = '0;
   logic [N-1:0][LO-1:0]   dest_i = '0;
   logic [N-1:0][LV-1:0]   output_vc_i = '0;
   logic                   cts = 0, last = 0;
   logic                   o_req, o_busy;
   logic [LO-1:0]          o_dest;
   logic [LV-1:0]          o_output_vc, selected_vc;
   logic [N-1:0]           o_grant;

   int total = 0, bad = 0;

   input_vc_arbiter #(.vc_num(VC), .prio_num(PRIO), .output_num(8)) dut (
      .clk(clk), .reset(reset), .has_packet(has_packet), .dest_i(dest_i),
      .output_vc_i(output_vc_i), .cts(cts), .last(last), .o_req(o_req),
      .o_dest(o_dest), .o_output_vc(o_output_vc), .selected_vc(selected_vc),
      .o_grant(o_grant), .o_busy(o_busy));

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: 0 idle, 1 requesting, 2 granted
   int m_state = 0, m_sel = 0, m_dest = 0, m_ovc = 0, m_rr0 = 0;
   int m_rr[PRIO];

   function automatic int winner(logic [N-1:0] hp);
`ifdef INPUT_ARB_STRICT_PRIO_EN
      for (int c = PRIO-1; c >= 0; c--)
         for (int k = 0; k < VC; k++) begin
            int j;
            j = c*VC + ((m_rr[c] - c*VC + k) % VC);
            if (hp[j]) return j;
         end
`else
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_rr0 + k) % N;
         if (hp[j]) return j;
      end
`endif
      return 0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_state = 0; m_sel = 0; m_dest = 0; m_ovc = 0; m_rr0 = 0;
         for (int c = 0; c < PRIO; c++) m_rr[c] = c*VC;
      end else begin
         case (m_state)
            0: if (has_packet != 0) begin
                  m_sel = winner(has_packet);
                  m_dest = int'(dest_i[m_sel]);
                  m_ovc = int'(output_vc_i[m_sel]);
                  m_state = 1;
               end
            1: if (cts) m_state = 2;
               else if (!has_packet[m_sel]) m_state = 0;
            default: if (last) begin
                  m_state = 0;
                  m_rr0 = (m_sel + 1) % N;
                  m_rr[m_sel / VC] = (m_sel / VC)*VC + ((m_sel % VC) + 1) % VC;
               end
         endcase
      end
      #1;
      check("o_req", int'(o_req), int'(m_state == 1));
      check("o_busy", int'(o_busy), int'(m_state != 0));
      check("o_grant", int'(o_grant), (m_state == 2) ? (1 << m_sel) : 0);
      check("selected_vc", int'(selected_vc), m_sel);
      check("o_dest", int'(o_dest), m_dest);
      check("o_output_vc", int'(o_output_vc), m_ovc);
   end

   int rise_vc[8];
   int rise_at[8];

   task automatic collect(input int n);
      int got;
      logic prev;
      got = 0;
      prev = o_req;
      for (int c = 0; c < 40 && got < n; c++) begin
         @(negedge clk);
         if (o_req && !prev) begin
            rise_vc[got] = int'(selected_vc);
            rise_at[got] = c;
            got++;
         end
         prev = o_req;
      end
      check("req_timeout", got, n);
   endtask

   task automatic do_reset();
      reset = 1; has_packet = '0; cts = 0; last = 0;
      @(negedge clk); @(negedge clk);
      reset = 0;
   endtask

   initial begin
      int first, second;
      // reset values
      do_reset();
      check("rst_req", int'(o_req), 0);
      check("rst_grant", int'(o_grant), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_sel", int'(selected_vc), 0);
      check("rst_dest", int'(o_dest), 0);
      check("rst_ovc", int'(o_output_vc), 0);

      // class priority vs flat round-robin
`ifdef INPUT_ARB_STRICT_PRIO_EN
      first = 3; second = 0;
`else
      first = 0; second = 3;
`endif
      do_reset();
      has_packet = 6'b001001; cts = 1; last = 1;
      collect(1);
      check("prio_first", rise_vc[0], first);
      has_packet = has_packet & ~(6'b1 << rise_vc[0]);
      collect(1);
      check("prio_second", rise_vc[0], second);

      // round-robin order and 3-cycle packet cadence
      do_reset();
      has_packet = 6'b000111; cts = 1; last = 1;
      collect(4);
      check("rr_0", rise_vc[0], 0);
      check("rr_1", rise_vc[1], 1);
      check("rr_2", rise_vc[2], 2);
      check("rr_3", rise_vc[3], 0);
      for (int i = 0; i < 3; i++) check("rr_gap", rise_at[i+1] - rise_at[i], 3);

      // request fields latched at selection
      do_reset();
      dest_i[2] = 3'd5; output_vc_i[2] = 3'd4; has_packet = 6'b000100;
      collect(1);
      check("lat_dest0", int'(o_dest), 5);
      check("lat_ovc0", int'(o_output_vc), 4);
      dest_i[2] = 3'd1; output_vc_i[2] = 3'd0;
      repeat (3) @(negedge clk);
      check("lat_req", int'(o_req), 1);
      check("lat_dest", int'(o_dest), 5);
      check("lat_ovc", int'(o_output_vc), 4);
      cts = 1; @(negedge clk);
      check("lat_grant", int'(o_grant), 6'b000100);
      last = 1; @(negedge clk);
      check("lat_done", int'(o_busy), 0);

      // withdrawal keeps the pointer; simultaneous cts wins
      do_reset();
      has_packet = 6'b000010; cts = 1; last = 1;
      collect(1);
      has_packet = '0;
      repeat (3) @(negedge clk);
      cts = 0; last = 0; has_packet = 6'b000100;
      collect(1);
      check("wd_sel", rise_vc[0], 2);
      has_packet = '0; @(negedge clk);
      check("wd_idle", int'(o_busy), 0);
      has_packet = 6'b000110;
      collect(1);
      check("wd_again", rise_vc[0], 2);
      has_packet = '0; cts = 1; @(negedge clk);
      check("wd_cts_wins", int'(o_grant), 6'b000100);
      cts = 0; last = 1; @(negedge clk);
      last = 0;

      // stray cts in IDLE and last in REQ
      do_reset();
      cts = 1; @(negedge clk);
      check("stray_cts", int'(o_busy), 0);
      cts = 0; last = 1; has_packet = 6'b000001; @(negedge clk);
      check("stray_req", int'(o_req), 1);
      @(negedge clk);
      check("stray_last_req", int'(o_req), 1);
      check("stray_last_grant", int'(o_grant), 0);
      last = 0; has_packet = '0; @(negedge clk);

      // reset while granted
      do_reset();
      has_packet = 6'b000100; cts = 1;
      collect(1);
      @(negedge clk);
      check("mid_grant", int'(o_grant), 6'b000100);
      reset = 1; @(negedge clk);
      check("mid_rst_grant", int'(o_grant), 0);
      check("mid_rst_req", int'(o_req), 0);
      check("mid_rst_busy", int'(o_busy), 0);
      reset = 0; cts = 0; has_packet = '0; @(negedge clk);
      check("mid_rst_after", int'(o_busy), 0);

      // randomized traffic, checked every cycle by the model
      repeat (3000) begin
         @(negedge clk);
         has_packet = N'($urandom_range(0, 63) & $urandom_range(0, 63));
         for (int i = 0; i < N; i++) begin
            dest_i[i] = LO'($urandom_range(0, 7));
            output_vc_i[i] = LV'($urandom_range(0, 5));
         end
         cts = ($urandom_range(0, 3) == 0);
         last = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
